tych_mac_rx_buffer: RTL and testbench
=====================================

# tych_mac_rx_buffer

Receive-side store-and-forward buffer between the MAC Avalon-ST RX interface (`mac_avlrx_t`) and the Tycho core. The MAC RX path has no backpressure. This block absorbs beats at line rate and commits only complete, error-free frames. It discards truncated, errored, orphaned and overflowing frames, then replays committed frames to the core over a ready/valid stream.

## Interface
- `DEPTH`, 64: buffer depth in 512-bit beats; power of 2, ≥ 4.
- `AW`, $clog2(DEPTH): pointer index width; pointers are AW+1 bits.

- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `mac_0_rx`  in  mac_avlrx_t: MAC RX beat. Fields used: `data[511:0]`, `sop`, `eop`, `valid`, `error`. No ready is returned.
- `rx_data`  out  512: beat to core.
- `rx_sop`  out  1: first beat of frame.
- `rx_eop`  out  1: last beat of frame.
- `rx_valid`  out  1: beat valid.
- `rx_ready`  in  1: core accepts beat when `rx_valid & rx_ready`.
- `rx_frames_ok`  out  32: committed frame count; wraps.
- `rx_frames_drop`  out  32: dropped frame count; wraps.

## Operation
- Storage is a DEPTH × 514 array holding {sop, eop, data}. It is written at `wr_ptr` and read combinationally at `rd_ptr` into the output register.
- Pointers:
  - `wr_ptr` is the speculative write pointer.
  - `cm_ptr` marks the end of committed data.
  - `rd_ptr` is the read pointer.
- `full` = (`wr_ptr` − `rd_ptr`) == DEPTH, evaluated with the current `rd_ptr`. A read in the same cycle does not free space.
- Rollback: `wr_ptr` ← `cm_ptr`. A drop event increments `rx_frames_drop` by 1.
- Write FSM states: IDLE, ACCEPT, DISCARD. Only `valid` beats are considered; non-valid cycles change nothing.
- Start-of-frame handling (SOF), applies to a `valid & sop` beat in any state:
  - If the prior state was ACCEPT or DISCARD, first roll back and count one drop for the abandoned frame.
  - If `error` or `full`: the frame is bad. If `eop`, count a drop and go to IDLE; otherwise go to DISCARD.
  - Otherwise write the beat and advance `wr_ptr`. If `eop`, commit and go to IDLE; otherwise go to ACCEPT.
- IDLE, beat with `!sop` (orphan): if `eop`, count a drop and stay in IDLE; otherwise go to DISCARD. Nothing is written.
- ACCEPT, beat with `!sop`:
  - If `error` or `full`: roll back. If `eop`, count a drop and go to IDLE; otherwise go to DISCARD.
  - Otherwise write the beat. If `eop`, commit: `cm_ptr` ← `wr_ptr`+1, `rx_frames_ok`++, go to IDLE.
- DISCARD, beat with `!sop`: not written. If `eop`, count a drop and go to IDLE.
- A frame longer than DEPTH beats always overflows and is dropped.
- Read side: the output register loads `mem[rd_ptr]` and `rd_ptr`++ when (`!rx_valid | rx_ready`) & (`rd_ptr` != `cm_ptr`). `rx_valid` deasserts when the register is consumed and no committed beat remains.
- `rx_sop`/`rx_eop` are replayed from storage. The core sees only whole frames, sop-first and eop-last.

## Timing
- Reset values:
  - All pointers 0, FSM in IDLE.
  - `rx_valid` 0, `rx_sop` 0, `rx_eop` 0, `rx_data` 0.
  - Both counters 0.
- Reset mid-frame discards all buffered and partial data with no counter updates.
- Commit latency: the eop beat is sampled at edge E0, `cm_ptr` updates at E0, and the first beat of that frame appears on `rx_valid` after edge E1. This holds if the output register was empty and the frame's first beat is at `rd_ptr`.
- Throughput is 1 beat/cycle on each side. Read and write proceed simultaneously and independently.
- `rx_valid`/`rx_data` hold stable while `rx_valid & !rx_ready`.
- Counters update on the edge that samples the deciding beat.
- When a truncation drop and a new frame's commit both occur on one `sop & eop` beat, both counters increment in the same cycle.
- Pointer arithmetic is modulo 2^(AW+1). The array index is the low AW bits.

## Test plan
- Clean traffic: three 4-beat frames back-to-back, `rx_ready`=1 → 12 beats out in order with correct sop/eop; `rx_frames_ok`=3, `rx_frames_drop`=0; the first output beat is 2 cycles after the first frame's eop.
- Errored frame: a 3-beat frame with `error` on beat 2, followed by a clean 2-beat frame → only the 2-beat frame is output; ok=1, drop=1.
- Truncation and orphan:
  - sop, data, then a new sop with no eop → first frame dropped, second delivered.
  - `!sop` beats with eop while IDLE → drop += 1, nothing output.
- Overflow (DEPTH=8, `rx_ready`=0):
  - A 6-beat frame, then a 4-beat frame → second frame dropped (drop=1), first retained.
  - Raise `rx_ready` → exactly 6 beats out.
  - A 9-beat frame into an empty buffer → dropped.
- Backpressure: random `rx_ready` toggling over 50 random-length clean frames → output data equals input, no beat lost or duplicated, held beats stable while stalled.
- Reset mid-operation: assert `rst` for 1 cycle while frames are buffered and `rx_valid`=1 → next cycle `rx_valid`=0 and counters 0; a subsequent frame is delivered normally.

Source files
------------

// File: rtl/tych_mac_pkg.sv
// Shared MAC-side bus payload types.
package tych_mac_pkg;

  localparam int unsigned MAC_DW = 512;

  typedef struct packed {
    logic [MAC_DW-1:0] data;
    logic              sop;
    logic              eop;
    logic              valid;
    logic              error;
  } mac_avlrx_t;

endpackage

// File: rtl/tych_mac_rx_buffer.sv
// Store-and-forward RX buffer: absorbs MAC beats at line rate, commits only whole
// error-free frames, and replays them to the core over a ready/valid stream.
module tych_mac_rx_buffer
  import tych_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  mac_avlrx_t        mac_0_rx,
  output logic [MAC_DW-1:0] rx_data,
  output logic              rx_sop,
  output logic              rx_eop,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [31:0]       rx_frames_ok,
  output logic [31:0]       rx_frames_drop
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned MW = MAC_DW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_DISCARD
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, wr_nxt;
  logic [PW-1:0]   cm_ptr, cm_nxt;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   base;
  logic            full_base, full_cur;
  logic            we;
  logic [AW-1:0]   wr_idx;
  logic            ok_inc;
  logic [1:0]      drop_inc;
  logic            rd_load;
  logic [MW-1:0]   rd_word;
  logic [MW-1:0]   mem [DEPTH];

  // A new sop abandons any open frame, so its space check uses the rolled-back pointer.
  assign base      = (state == S_IDLE) ? wr_ptr : cm_ptr;
  assign full_base = (base - rd_ptr) == PW'(DEPTH);
  assign full_cur  = (wr_ptr - rd_ptr) == PW'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_nxt;
      cm_ptr <= cm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cm_nxt    = cm_ptr;
    we        = 1'b0;
    wr_idx    = wr_ptr[AW-1:0];
    ok_inc    = 1'b0;
    drop_inc  = 2'd0;
    if (mac_0_rx.valid) begin
      if (mac_0_rx.sop) begin
        if (state != S_IDLE) drop_inc = 2'd1;
        wr_nxt = base;
        if (mac_0_rx.error || full_base) begin
          if (mac_0_rx.eop) begin
            drop_inc  = drop_inc + 2'd1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DISCARD;
          end
        end else begin
          we     = 1'b1;
          wr_idx = base[AW-1:0];
          wr_nxt = base + PW'(1);
          if (mac_0_rx.eop) begin
            cm_nxt    = base + PW'(1);
            ok_inc    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ACCEPT;
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (mac_0_rx.eop) drop_inc = 2'd1;
            else              state_nxt = S_DISCARD;
          end
          S_ACCEPT: begin
            if (mac_0_rx.error || full_cur) begin
              wr_nxt = cm_ptr;
              if (mac_0_rx.eop) begin
                drop_inc  = 2'd1;
                state_nxt = S_IDLE;
              end else begin
                state_nxt = S_DISCARD;
              end
            end else begin
              we     = 1'b1;
              wr_nxt = wr_ptr + PW'(1);
              if (mac_0_rx.eop) begin
                cm_nxt    = wr_ptr + PW'(1);
                ok_inc    = 1'b1;
                state_nxt = S_IDLE;
              end
            end
          end
          S_DISCARD: begin
            if (mac_0_rx.eop) begin
              drop_inc  = 2'd1;
              state_nxt = S_IDLE;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Frame storage; contents are meaningless until covered by cm_ptr, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= {mac_0_rx.sop, mac_0_rx.eop, mac_0_rx.data};
  end

  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign rd_load = (!rx_valid || rx_ready) && (rd_ptr != cm_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      rx_valid <= 1'b0;
      rx_sop   <= 1'b0;
      rx_eop   <= 1'b0;
      rx_data  <= '0;
    end else if (rd_load) begin
      rd_ptr   <= rd_ptr + PW'(1);
      rx_valid <= 1'b1;
      rx_sop   <= rd_word[MW-1];
      rx_eop   <= rd_word[MW-2];
      rx_data  <= rd_word[MAC_DW-1:0];
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_frames_ok   <= '0;
      rx_frames_drop <= '0;
    end else begin
      rx_frames_ok   <= rx_frames_ok + 32'(ok_inc);
      rx_frames_drop <= rx_frames_drop + 32'(drop_inc);
    end
  end

endmodule

// File: tb/tb_tych_mac_rx_buffer.sv
// Bench for tych_mac_rx_buffer: table-driven frame stream plus overflow,
// backpressure and reset sequences.
module tb_tych_mac_rx_buffer;
  import tych_mac_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  mac_avlrx_t        mac;
  logic [MAC_DW-1:0] rx_data;
  logic              rx_sop;
  logic              rx_eop;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       rx_frames_ok;
  logic [31:0]       rx_frames_drop;

  always #5 clk = ~clk;

  tych_mac_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mac_0_rx       (mac),
    .rx_data        (rx_data),
    .rx_sop         (rx_sop),
    .rx_eop         (rx_eop),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_frames_ok   (rx_frames_ok),
    .rx_frames_drop (rx_frames_drop)
  );

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [MAC_DW-1:0] data;
  } beat_t;

  typedef struct {
    logic        v;
    logic        sop;
    logic        eop;
    logic        err;
    logic [15:0] tag;
    int          ok;
    int          drop;
  } vec_t;

  beat_t got[$];
  beat_t exp_q[$];
  vec_t  vq[$];
  int    checks = 0;
  int    errors = 0;
  logic  held = 1'b0;
  beat_t held_beat;
  logic  rand_ready = 1'b0;

  task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MAC_DW-1:0] mk(input logic [15:0] tag);
    return {32{tag}};
  endfunction

  // One clock: monitor at negedge, then advance to just after the posedge.
  task automatic tick();
    @(negedge clk);
    if (held)
      check("hold_stable", 520'({rx_valid, rx_sop, rx_eop, rx_data}), 520'({1'b1, held_beat}));
    held      = !rst && rx_valid && !rx_ready;
    held_beat = {rx_sop, rx_eop, rx_data};
    if (!rst && rx_valid && rx_ready) got.push_back(beat_t'({rx_sop, rx_eop, rx_data}));
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic v, input logic sop, input logic eop, input logic err,
                      input logic [15:0] tag);
    mac.valid = v;
    mac.sop   = sop;
    mac.eop   = eop;
    mac.error = err;
    mac.data  = mk(tag);
    tick();
  endtask

  task automatic drain(input int n);
    mac = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    mac = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic v, input logic sop, input logic eop, input logic err,
                     input logic [15:0] tag, input int ok, input int drop);
    vec_t e;
    e.v = v; e.sop = sop; e.eop = eop; e.err = err; e.tag = tag; e.ok = ok; e.drop = drop;
    vq.push_back(e);
  endtask

  task automatic expb(input logic sop, input logic eop, input logic [15:0] tag);
    exp_q.push_back(beat_t'({sop, eop, mk(tag)}));
  endtask

  task automatic compare_out(input string name);
    check({name, "_count"}, 520'(got.size()), 520'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(name, 520'(got[i]), 520'(exp_q[i]));
  endtask

  initial begin
    int sent;
    int len;
    int w;

    //   v  sop eop err tag       ok drop
    add(1, 1, 0, 0, 16'h0101, 0, 0);
    add(1, 0, 0, 0, 16'h0102, 0, 0);
    add(1, 0, 0, 0, 16'h0103, 0, 0);
    add(1, 0, 1, 0, 16'h0104, 1, 0);
    add(1, 1, 0, 0, 16'h0201, 1, 0);
    add(1, 0, 0, 0, 16'h0202, 1, 0);
    add(1, 0, 0, 0, 16'h0203, 1, 0);
    add(1, 0, 1, 0, 16'h0204, 2, 0);
    add(1, 1, 0, 0, 16'h0301, 2, 0);
    add(1, 0, 0, 0, 16'h0302, 2, 0);
    add(1, 0, 0, 0, 16'h0303, 2, 0);
    add(1, 0, 1, 0, 16'h0304, 3, 0);
    add(0, 0, 0, 0, 16'h0000, 3, 0);
    add(1, 1, 0, 0, 16'h0401, 3, 0);  // errored frame
    add(1, 0, 0, 1, 16'h0402, 3, 0);
    add(1, 0, 1, 0, 16'h0403, 3, 1);
    add(1, 1, 0, 0, 16'h0501, 3, 1);
    add(1, 0, 1, 0, 16'h0502, 4, 1);
    add(1, 1, 0, 0, 16'h0601, 4, 1);  // truncated by new sop
    add(1, 0, 0, 0, 16'h0602, 4, 1);
    add(1, 1, 0, 0, 16'h0701, 4, 2);
    add(1, 0, 1, 0, 16'h0702, 5, 2);
    add(1, 0, 1, 0, 16'h0801, 5, 3);  // orphans
    add(1, 0, 0, 0, 16'h0901, 5, 3);
    add(1, 0, 1, 0, 16'h0902, 5, 4);
    add(1, 1, 0, 0, 16'h0a01, 5, 4);  // drop + commit on one beat
    add(1, 1, 1, 0, 16'h0b01, 6, 5);
    add(1, 1, 0, 0, 16'h0c01, 6, 5);
    add(0, 1, 1, 0, 16'hdead, 6, 5);
    add(1, 0, 1, 0, 16'h0c02, 7, 5);
    add(1, 1, 0, 0, 16'h0d01, 7, 5);  // abandon + errored single beat
    add(1, 1, 1, 1, 16'h0e01, 7, 7);
    add(1, 1, 1, 1, 16'h0f01, 7, 8);

    for (int f = 1; f <= 3; f++)
      for (int b = 1; b <= 4; b++) expb(b == 1, b == 4, 16'((f << 8) | b));
    expb(1, 0, 16'h0501); expb(0, 1, 16'h0502);
    expb(1, 0, 16'h0701); expb(0, 1, 16'h0702);
    expb(1, 1, 16'h0b01);
    expb(1, 0, 16'h0c01); expb(0, 1, 16'h0c02);

    mac      = '0;
    rx_ready = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", 520'(rx_valid), 520'(0));
    check("reset_flags", 520'({rx_sop, rx_eop}), 520'(0));
    check("reset_data", 520'(rx_data), 520'(0));
    check("reset_ok", 520'(rx_frames_ok), 520'(0));
    check("reset_drop", 520'(rx_frames_drop), 520'(0));

    // Table-driven stream with the core always ready
    rx_ready = 1'b1;
    got.delete();
    for (int i = 0; i < vq.size(); i++) begin
      send(vq[i].v, vq[i].sop, vq[i].eop, vq[i].err, vq[i].tag);
      check("vec_ok", 520'(rx_frames_ok), 520'(vq[i].ok));
      check("vec_drop", 520'(rx_frames_drop), 520'(vq[i].drop));
      if (i == 3) check("latency_e0_valid", 520'(rx_valid), 520'(0));
      if (i == 4) check("latency_e1_beat", 520'({rx_valid, rx_sop, rx_data}),
                        520'({1'b1, 1'b1, mk(16'h0101)}));
    end
    drain(10);
    compare_out("stream_out");

    // Overflow with the core stalled
    do_reset();
    rx_ready = 1'b0;
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) send(1, i == 0, i == 5, 0, 16'(16'h1000 + i));
    for (int i = 0; i < 4; i++) send(1, i == 0, i == 3, 0, 16'(16'h2000 + i));
    check("ovf_ok", 520'(rx_frames_ok), 520'(1));
    check("ovf_drop", 520'(rx_frames_drop), 520'(1));
    drain(2);
    check("ovf_head", 520'({rx_valid, rx_sop, rx_data}), 520'({1'b1, 1'b1, mk(16'h1000)}));
    rx_ready = 1'b1;
    drain(12);
    for (int i = 0; i < 6; i++) expb(i == 0, i == 5, 16'(16'h1000 + i));
    compare_out("ovf_out");
    for (int i = 0; i < 9; i++) send(1, i == 0, i == 8, 0, 16'(16'h3000 + i));
    check("long_ok", 520'(rx_frames_ok), 520'(1));
    check("long_drop", 520'(rx_frames_drop), 520'(2));
    drain(6);
    compare_out("long_out");

    // Random backpressure over clean frames, paced so nothing can overflow
    do_reset();
    got.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    sent = 0;
    for (int f = 0; f < 50; f++) begin
      len = int'($urandom_range(1, 6));
      w = 0;
      mac = '0;
      while ((sent - got.size() + len > int'(DEPTH)) && (w < 300)) begin
        tick();
        w++;
      end
      check("space_wait", 520'(w < 300), 520'(1));
      for (int b = 0; b < len; b++) begin
        send(1, b == 0, b == len - 1, 0, 16'(16'h4000 + (f << 4) + b));
        expb(b == 0, b == len - 1, 16'(16'h4000 + (f << 4) + b));
        sent++;
      end
    end
    rand_ready = 1'b0;
    rx_ready   = 1'b1;
    drain(30);
    compare_out("bp_out");
    check("bp_ok", 520'(rx_frames_ok), 520'(50));
    check("bp_drop", 520'(rx_frames_drop), 520'(0));

    // Reset while frames are buffered
    do_reset();
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1, i == 0, i == 2, 0, 16'(16'h5000 + i));
    for (int i = 0; i < 2; i++) send(1, i == 0, i == 1, 0, 16'(16'h5100 + i));
    drain(2);
    check("pre_rst_valid", 520'(rx_valid), 520'(1));
    check("pre_rst_ok", 520'(rx_frames_ok), 520'(2));
    do_reset();
    check("post_rst_valid", 520'(rx_valid), 520'(0));
    check("post_rst_cnt", 520'({rx_frames_ok, rx_frames_drop}), 520'(0));
    got.delete();
    exp_q.delete();
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) send(1, i == 0, i == 1, 0, 16'(16'h5200 + i));
    expb(1, 0, 16'h5200);
    expb(0, 1, 16'h5201);
    drain(6);
    compare_out("post_rst_out");
    check("post_rst_ok", 520'(rx_frames_ok), 520'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
